// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one bit per cycle, start-to-done in XLEN+1 cycles, result held until next done.
// Optional MULDIV_FAST_ZERO_EN: a zero operand bypasses CALC and completes in the cycle after start.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   op_q, op_d;
   logic [2:0]        func3_q, func3_d;
   logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;

   always_comb begin
      is_div = func3[2];
      a_sgn  = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
      b_sgn  = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
      a_neg  = a_sgn & rs1_data[XLEN-1];
      b_neg  = b_sgn & rs2_data[XLEN-1];
      a_mag  = a_neg ? (~rs1_data + 1'b1) : rs1_data;
      b_mag  = b_neg ? (~rs2_data + 1'b1) : rs2_data;
   end

   // acc holds {hi, lo}: product accumulator for multiply, {remainder, quotient/dividend} for divide
   logic [XLEN:0]     mul_sum, div_sh;
   logic [XLEN-1:0]   div_sub;
   logic              div_ge;
   logic [2*XLEN-1:0] step_nxt, prod;
   logic [XLEN-1:0]   quo, rem, fin;

   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, ({XLEN{acc_q[0]}} & op_q)};
      div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_ge  = div_sh >= {1'b0, op_q};
      div_sub = div_sh[XLEN-1:0] - op_q;
      if (func3_q[2])
         step_nxt = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                           : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
         step_nxt = {mul_sum, acc_q[XLEN-1:1]};
      prod = neg_q ? (~step_nxt + 1'b1) : step_nxt;
      quo  = dz_q ? '1 : (neg_q ? (~step_nxt[XLEN-1:0] + 1'b1) : step_nxt[XLEN-1:0]);
      rem  = rneg_q ? (~step_nxt[2*XLEN-1:XLEN] + 1'b1) : step_nxt[2*XLEN-1:XLEN];
      case (func3_q)
         3'b000:                 fin = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin = quo;
         default:                fin = rem;
      endcase
   end

`ifdef MULDIV_FAST_ZERO_EN
   logic            fz_hit;
   logic [XLEN-1:0] fz_res;

   always_comb begin
      fz_hit = (rs1_data == '0) || (rs2_data == '0);
      fz_res = '0;
      if (is_div && (rs2_data == '0))
         fz_res = func3[1] ? rs1_data : '1;
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      op_d     = op_q;
      func3_d  = func3_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               func3_d = func3;
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               dz_d    = (rs2_data == '0);
               cnt_d   = '0;
               op_d    = is_div ? b_mag : a_mag;
               acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
               state_d = CALC;
`ifdef MULDIV_FAST_ZERO_EN
               if (fz_hit) begin
                  state_d  = DONE;
                  result_d = fz_res;
               end
`endif
            end
         end
         CALC: begin
            acc_d = step_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
               state_d  = DONE;
               result_d = fin;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // flush beats everything, including a start in IDLE, and leaves the old result visible
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         func3_q  <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         func3_q  <= func3_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign stall  = ((state_q == IDLE) && start) || (state_q == CALC);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized bench for muldiv_seq, checked against a plain-arithmetic RV32M model.
// Define MULDIV_FAST_ZERO_EN on both files to cover the zero-operand bypass latency.
module tb_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  func3;
   logic [31:0] rs1_data, rs2_data;
   logic        busy, stall, done;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_exp = '0;

   always #5 clk = ~clk;

   muldiv_seq #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .func3    (func3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .flush    (flush),
      .busy     (busy),
      .stall    (stall),
      .done     (done),
      .result   (result)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = '0;
      case (f)
         3'd0: begin p = ua * ub; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
         3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
      if (a == 0 || b == 0) return 1;
`endif
      return 33;
   endfunction

   // Entered and left at a falling edge; cycle 0 is the one with start high.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int lat, k;
      bit seen;
      lat = exp_lat(a, b);
      func3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
      #1;
      check_eq({tag, ":stall0"}, 32'(stall), 32'd1);
      check_eq({tag, ":busy0"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         check_eq({tag, ":busy"}, 32'(busy), 32'(k <= lat));
         check_eq({tag, ":stall"}, 32'(stall), 32'(k < lat));
         if (done) seen = 1'b1;
      end
      if (!seen) check_eq({tag, ":timeout"}, 32'd0, 32'd1);
      check_eq({tag, ":lat"}, 32'(k), 32'(lat));
      check_eq({tag, ":res"}, result, exp);
      last_exp = exp;
      @(negedge clk);
      check_eq({tag, ":pulse"}, 32'(done), 32'd0);
      check_eq({tag, ":idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int t1, t2, nd, k;
      logic [2:0]  f;
      logic [31:0] a, b;

      rst = 1'b1; start = 1'b0; flush = 1'b0;
      func3 = '0; rs1_data = '0; rs2_data = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_stall", 32'(stall), 32'd0);
      check_eq("rst_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("mul",    3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB);
      run_op("mulh",   3'd1, 32'h80000000,  32'h80000000, 32'h40000000);
      run_op("mulhu",  3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE);
      run_op("mulhsu", 3'd2, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF);
      run_op("div",    3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD);
      run_op("rem",    3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF);
      run_op("divu",   3'd5, 32'd100,       32'd7,        32'd14);
      run_op("remu",   3'd7, 32'd100,       32'd7,        32'd2);
      run_op("divu0",  3'd5, 32'h1234,      32'd0,        32'hFFFFFFFF);
      run_op("rem0",   3'd6, 32'h1234,      32'd0,        32'h1234);
      run_op("div0",   3'd4, 32'h1234,      32'd0,        32'hFFFFFFFF);
      run_op("divov",  3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000);
      run_op("remov",  3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0);

      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: a = '0;
            2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            3: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op("rand", f, a, b, model(f, a, b));
      end

      // flush in CALC: no done, previous result stays
      func3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check_eq("flush_busy", 32'(busy), 32'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check_eq("flush_nodone", 32'(nd), 32'd0);
      check_eq("flush_result", result, last_exp);

      // flush and start together in IDLE: nothing starts
      func3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 begin start = 1'b0; flush = 1'b0; end
      @(negedge clk);
      check_eq("flushstart_busy", 32'(busy), 32'd0);

      // reset mid-CALC
      func3 = 3'd1; rs1_data = 32'h12345678; rs2_data = 32'h9ABCDEF0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_done", 32'(done), 32'd0);
      check_eq("arst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_exp = '0;
      @(negedge clk);

      // start held through busy; second op presented after the first done
      func3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
      t1 = 0; t2 = 0; k = 0;
      while (t2 == 0 && k < 120) begin
         @(negedge clk);
         k++;
         if (done && t1 == 0) begin
            t1 = k;
            check_eq("b2b_res1", result, 32'd14);
            func3 = 3'd3; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF;
         end else if (done) begin
            t2 = k;
            check_eq("b2b_res2", result, 32'hFFFFFFFE);
            start = 1'b0;
         end
      end
      start = 1'b0;
      check_eq("b2b_first", 32'(t1), 32'd33);
      check_eq("b2b_gap", 32'(t2 - t1), 32'd34);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
